mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage access controller: access types,
// operand lengths and controller states.
package mem_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_LOAD  = 2'b01;
  localparam logic [1:0] RW_STORE = 2'b10;

  localparam logic [2:0] LEN_BYTE_S = 3'b000;
  localparam logic [2:0] LEN_HALF_S = 3'b001;
  localparam logic [2:0] LEN_WORD   = 3'b010;
  localparam logic [2:0] LEN_BYTE_U = 3'b100;
  localparam logic [2:0] LEN_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  // Any length code that is neither a byte nor a half is handled as a word.
  function automatic logic len_is_byte(input logic [2:0] len);
    return (len == LEN_BYTE_S) || (len == LEN_BYTE_U);
  endfunction

  function automatic logic len_is_half(input logic [2:0] len);
    return (len == LEN_HALF_S) || (len == LEN_HALF_U);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of the
// returned word and sign- or zero-extends it; words pass straight through.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr,
  input  logic [2:0]  length,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = data[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr];
  assign half_sel = addr[1] ? data[31:16] : data[15:0];

  always_comb begin
    result = data;
    case (length)
      LEN_BYTE_S: result = {{24{byte_sel[7]}}, byte_sel};
      LEN_BYTE_U: result = {24'h0, byte_sel};
      LEN_HALF_S: result = {{16{half_sel[15]}}, half_sel};
      LEN_HALF_U: result = {16'h0, half_sel};
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: TLB translation, cache request handshake,
// store lane steering and load formatting. Optional MEM_ALIGN_CHECK_EN traps misaligned accesses.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  memory_rw,
  input  logic [2:0]  number_length,
  input  logic [31:0] v_addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  input  logic        tlb_hit,
  input  logic [63:0] tlb_read,
  output logic [31:0] p_addr,
  output logic        p_addr_valid,
  output logic [1:0]  cache_rw,
  output logic [31:0] cache_write,
  output logic [3:0]  cache_wstrb,
  input  logic        cache_ready,
  input  logic [31:0] cache_read,
  output logic [31:0] mem_result,
  output logic        done,
  output logic        stall,
  output logic        tlb_miss_exc,
  output logic        align_exc
);

  state_t      state_reg, state_next;
  logic [1:0]  rw_reg, rw_next;
  logic [2:0]  len_reg, len_next;
  logic [1:0]  addr_lo_reg, addr_lo_next;
  logic [31:0] p_addr_reg, p_addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [31:0] result_reg, result_next;
  logic        drop_reg, drop_next;
  logic        tlb_miss_reg, tlb_miss_next;
  logic        align_exc_reg, align_exc_next;
  logic        accept, misaligned;
  logic [31:0] load_result, lane_data;
  logic [3:0]  lane_strb;
  logic        unused_bits;

  assign unused_bits = ^{tlb_read[63:32], tlb_read[11:0], v_addr[31:12]};

  mem_load_align u_load_align (
    .data   (cache_read),
    .addr   (addr_lo_reg),
    .length (len_reg),
    .result (load_result)
  );

  assign accept = req_valid && !flush && (memory_rw == RW_LOAD || memory_rw == RW_STORE);

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    if (len_is_byte(number_length))      misaligned = 1'b0;
    else if (len_is_half(number_length)) misaligned = v_addr[0];
    else                                 misaligned = (v_addr[1:0] != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store operand is right-aligned; replicate it so every lane sees it and let wstrb pick.
  always_comb begin
    lane_data = store_data;
    lane_strb = 4'b1111;
    if (len_is_byte(number_length)) begin
      lane_data = {4{store_data[7:0]}};
      lane_strb = 4'b0001 << v_addr[1:0];
    end else if (len_is_half(number_length)) begin
      lane_data = {2{store_data[15:0]}};
      lane_strb = v_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rw_next        = rw_reg;
    len_next       = len_reg;
    addr_lo_next   = addr_lo_reg;
    p_addr_next    = p_addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    result_next    = result_reg;
    drop_next      = drop_reg;
    tlb_miss_next  = 1'b0;
    align_exc_next = 1'b0;
    stall          = 1'b0;
    done           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            align_exc_next = 1'b1;
          end else if (!tlb_hit) begin
            tlb_miss_next = 1'b1;
          end else begin
            stall        = 1'b1;
            state_next   = ST_ISSUE;
            rw_next      = memory_rw;
            len_next     = number_length;
            addr_lo_next = v_addr[1:0];
            p_addr_next  = {tlb_read[31:12], v_addr[11:0]};
            wdata_next   = lane_data;
            wstrb_next   = (memory_rw == RW_STORE) ? lane_strb : 4'b0000;
            drop_next    = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        // A flush here cannot retract the request already on the cache port;
        // remember it and discard the response instead.
        stall = 1'b1;
        if (flush) drop_next = 1'b1;
        if (cache_ready) begin
          drop_next = 1'b0;
          if (drop_reg || flush) begin
            state_next = ST_IDLE;
          end else begin
            state_next  = ST_RESP;
            result_next = (rw_reg == RW_LOAD) ? load_result : 32'h0;
          end
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        done       = !flush;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rw_reg        <= RW_NONE;
      len_reg       <= LEN_WORD;
      addr_lo_reg   <= 2'b00;
      p_addr_reg    <= 32'h0;
      wdata_reg     <= 32'h0;
      wstrb_reg     <= 4'b0000;
      result_reg    <= 32'h0;
      drop_reg      <= 1'b0;
      tlb_miss_reg  <= 1'b0;
      align_exc_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rw_reg        <= rw_next;
      len_reg       <= len_next;
      addr_lo_reg   <= addr_lo_next;
      p_addr_reg    <= p_addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      result_reg    <= result_next;
      drop_reg      <= drop_next;
      tlb_miss_reg  <= tlb_miss_next;
      align_exc_reg <= align_exc_next;
    end
  end

  assign p_addr_valid = (state_reg == ST_ISSUE);
  assign cache_rw     = (state_reg == ST_ISSUE) ? rw_reg : RW_NONE;
  assign cache_wstrb  = (state_reg == ST_ISSUE) ? wstrb_reg : 4'b0000;
  assign p_addr       = p_addr_reg;
  assign cache_write  = wdata_reg;
  assign mem_result   = result_reg;
  assign tlb_miss_exc = tlb_miss_reg;
  assign align_exc    = align_exc_reg;

endmodule
